// File: rtl/dmem_mmio.sv
// Data memory with a small memory-mapped register block: LED, free-running
// timer with compare/match flag, program-exit latch and a sticky flag for
// writes to unmapped addresses.
// Optional timer (TCOUNT/TCMP/STATUS/Irq) is built only when DMEM_TIMER_EN is
// defined; otherwise those offsets read 0, ignore writes and Irq is tied low.
module dmem_mmio #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  Led,
  output logic        Irq,
  output logic        Done,
  output logic [31:0] ExitCode,
  output logic        AccErr
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [29:0] BaseWord = MMIO_BASE[31:2];

  // Address decode; RAM takes precedence should the regions ever overlap.
  logic            ram_hit;
  logic [IdxW-1:0] ram_idx;
  logic            led_hit, tcnt_hit, tcmp_hit, stat_hit, exit_hit;
  logic            unmapped;

  assign ram_hit  = (Addr < RamBytes);
  assign ram_idx  = Addr[IdxW+1:2];
  assign led_hit  = !ram_hit && (Addr[31:2] == BaseWord);
  assign tcnt_hit = !ram_hit && (Addr[31:2] == BaseWord + 30'd1);
  assign tcmp_hit = !ram_hit && (Addr[31:2] == BaseWord + 30'd2);
  assign stat_hit = !ram_hit && (Addr[31:2] == BaseWord + 30'd3);
  assign exit_hit = !ram_hit && (Addr[31:2] == BaseWord + 30'd4);
  // Timer offsets stay mapped even when the timer is not built.
  assign unmapped = !(ram_hit || led_hit || tcnt_hit || tcmp_hit || stat_hit || exit_hit);

  // RAM storage: no reset, and writes are suppressed while reset is held.
  logic [31:0] mem [DEPTH_WORDS];

  // RAM write port.
  always_ff @(posedge clk) begin
    if (reset && MemWrite && ram_hit) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // Control registers.
  logic [7:0]  led_q, led_d;
  logic        done_q, done_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        acc_err_q, acc_err_d;

  // Next-state for LED, exit latch and access-error flag.
  always_comb begin
    led_d       = led_q;
    done_d      = done_q;
    exit_code_d = exit_code_q;
    acc_err_d   = acc_err_q;
    if (MemWrite && led_hit) begin
      led_d = WriteData[7:0];
    end
    // Only the first EXIT write is captured.
    if (MemWrite && exit_hit && !done_q) begin
      done_d      = 1'b1;
      exit_code_d = WriteData;
    end
    if (MemWrite && unmapped) begin
      acc_err_d = 1'b1;
    end
  end

  // Control register state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q       <= 8'h00;
      done_q      <= 1'b0;
      exit_code_q <= 32'h0;
      acc_err_q   <= 1'b0;
    end else begin
      led_q       <= led_d;
      done_q      <= done_d;
      exit_code_q <= exit_code_d;
      acc_err_q   <= acc_err_d;
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        match_q, match_d;

  // Timer next-state: load beats increment, match set beats W1C clear.
  always_comb begin
    tcount_d = tcount_q + 32'd1;
    tcmp_d   = tcmp_q;
    match_d  = match_q;
    if (MemWrite && tcnt_hit) begin
      tcount_d = WriteData;
    end
    if (MemWrite && tcmp_hit) begin
      tcmp_d = WriteData;
    end
    if (MemWrite && stat_hit && WriteData[0]) begin
      match_d = 1'b0;
    end
    if ((tcount_q == tcmp_q) && (tcmp_q != 32'h0)) begin
      match_d = 1'b1;
    end
  end

  // Timer state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount_q <= 32'h0;
      tcmp_q   <= 32'h0;
      match_q  <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
    end
  end

  assign Irq = match_q;
`else
  assign Irq = 1'b0;
`endif

  // Combinational load data from current (pre-write) state.
  always_comb begin
    ReadData = 32'h0;
    if (ram_hit) begin
      ReadData = mem[ram_idx];
    end else if (led_hit) begin
      ReadData = {24'h0, led_q};
`ifdef DMEM_TIMER_EN
    end else if (tcnt_hit) begin
      ReadData = tcount_q;
    end else if (tcmp_hit) begin
      ReadData = tcmp_q;
    end else if (stat_hit) begin
      ReadData = {31'h0, match_q};
`endif
    end
  end

  assign Led      = led_q;
  assign Done     = done_q;
  assign ExitCode = exit_code_q;
  assign AccErr   = acc_err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus pushes expected values, a monitor
// on the falling edge pops and compares them against the DUT outputs.
// Timer checks are built only when DMEM_TIMER_EN is defined.
module tb_dmem_mmio;

  localparam logic [31:0] ALed  = 32'h0000_1000;
  localparam logic [31:0] ATcnt = 32'h0000_1004;
  localparam logic [31:0] ATcmp = 32'h0000_1008;
  localparam logic [31:0] AStat = 32'h0000_100C;
  localparam logic [31:0] AExit = 32'h0000_1010;

  localparam int SelRd   = 0;
  localparam int SelLed  = 1;
  localparam int SelIrq  = 2;
  localparam int SelDone = 3;
  localparam int SelExit = 4;
  localparam int SelErr  = 5;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  Led;
  logic        Irq;
  logic        Done;
  logic [31:0] ExitCode;
  logic        AccErr;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Led       (Led),
    .Irq       (Irq),
    .Done      (Done),
    .ExitCode  (ExitCode),
    .AccErr    (AccErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      sb_entry_t   e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        SelRd:   act = ReadData;
        SelLed:  act = {24'h0, Led};
        SelIrq:  act = {31'h0, Irq};
        SelDone: act = {31'h0, Done};
        SelExit: act = ExitCode;
        default: act = {31'h0, AccErr};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    Addr      = a;
    WriteData = d;
  endtask

  task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
    sb_entry_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_val("rst_led", SelLed, 32'h0);
    expect_val("rst_done", SelDone, 32'h0);
    expect_val("rst_exit", SelExit, 32'h0);
    expect_val("rst_accerr", SelErr, 32'h0);
    expect_val("rst_irq", SelIrq, 32'h0);
    step();
    reset = 1'b1;

`ifdef DMEM_TIMER_EN
    drive(1'b0, ATcnt, 32'h0);
    expect_val("tcnt_after_rst0", SelRd, 32'h0);
    step();
    expect_val("tcnt_after_rst1", SelRd, 32'h1);
    step();
`endif

    // Unmapped read must not flag.
    drive(1'b0, 32'h0000_2000, 32'h0);
    expect_val("unmapped_rd0", SelRd, 32'h0);
    step();
    expect_val("unmapped_rd_noflag", SelErr, 32'h0);

    // RAM
    drive(1'b1, 32'h0, 32'hCAFE_0000);
    step();
    drive(1'b1, 32'h10, 32'h1111_1111);
    step();
    drive(1'b1, 32'h10, 32'hDEAD_BEEF);
    expect_val("ram_same_cycle_old", SelRd, 32'h1111_1111);
    step();
    drive(1'b0, 32'h10, 32'h0);
    expect_val("ram_rd_10", SelRd, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 32'h13, 32'h0);
    expect_val("ram_rd_13", SelRd, 32'hDEAD_BEEF);
    step();

    // LED
    drive(1'b1, ALed, 32'h1234_56A5);
    step();
    drive(1'b0, ALed, 32'h0);
    expect_val("led_rd", SelRd, 32'h0000_00A5);
    expect_val("led_port", SelLed, 32'h0000_00A5);
    step();

`ifdef DMEM_TIMER_EN
    drive(1'b1, ATcnt, 32'h100);
    step();
    drive(1'b1, ATcmp, 32'h5);
    step();
    drive(1'b1, ATcnt, 32'h0);
    expect_val("tcnt_prewrite", SelRd, 32'h101);
    step();
    drive(1'b0, ATcnt, 32'h0);
    expect_val("tcnt_loaded0", SelRd, 32'h0);
    expect_val("irq_before", SelIrq, 32'h0);
    step();
    drive(1'b0, ATcmp, 32'h0);
    expect_val("tcmp_rd", SelRd, 32'h5);
    step();
    repeat (3) step();
    drive(1'b0, ATcnt, 32'h0);
    expect_val("tcnt_eq5", SelRd, 32'h5);
    expect_val("irq_not_yet", SelIrq, 32'h0);
    step();
    drive(1'b1, AStat, 32'h1);
    expect_val("irq_set", SelIrq, 32'h1);
    expect_val("status_rd", SelRd, 32'h1);
    step();
    drive(1'b1, ATcnt, 32'h5);
    expect_val("irq_cleared", SelIrq, 32'h0);
    step();
    drive(1'b1, AStat, 32'h1);
    expect_val("irq_pre_coincide", SelIrq, 32'h0);
    step();
    drive(1'b1, ATcnt, 32'hFFFF_FFFF);
    expect_val("irq_set_wins", SelIrq, 32'h1);
    step();
    drive(1'b0, ATcnt, 32'h0);
    expect_val("tcnt_max", SelRd, 32'hFFFF_FFFF);
    step();
    drive(1'b1, ATcnt, 32'h1234);
    expect_val("tcnt_wrap", SelRd, 32'h0);
    step();
    drive(1'b0, ATcnt, 32'h0);
    expect_val("tcnt_load_wins", SelRd, 32'h1234);
    step();
    drive(1'b1, AStat, 32'h1);
    expect_val("irq_before_clr", SelIrq, 32'h1);
    step();
    drive(1'b0, AStat, 32'h0);
    expect_val("status_clr", SelRd, 32'h0);
    expect_val("irq_clr2", SelIrq, 32'h0);
    step();
`else
    drive(1'b1, ATcnt, 32'h55);
    step();
    drive(1'b1, ATcmp, 32'h5);
    step();
    drive(1'b1, AStat, 32'h1);
    step();
    drive(1'b0, ATcnt, 32'h0);
    expect_val("notimer_tcnt", SelRd, 32'h0);
    expect_val("notimer_noerr", SelErr, 32'h0);
    expect_val("notimer_irq", SelIrq, 32'h0);
    step();
    drive(1'b0, ATcmp, 32'h0);
    expect_val("notimer_tcmp", SelRd, 32'h0);
    step();
    drive(1'b0, AStat, 32'h0);
    expect_val("notimer_stat", SelRd, 32'h0);
    step();
`endif

    // Unmapped write: flag set, nothing else changes.
    drive(1'b1, 32'h0000_2000, 32'hFFFF_FFFF);
    expect_val("accerr_before", SelErr, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    expect_val("accerr_set", SelErr, 32'h1);
    expect_val("unmapped_ram0", SelRd, 32'hCAFE_0000);
    expect_val("unmapped_led", SelLed, 32'h0000_00A5);
    step();
    drive(1'b0, 32'h0000_2000, 32'h0);
    expect_val("unmapped_rd", SelRd, 32'h0);
    step();
    drive(1'b0, 32'h10, 32'h0);
    expect_val("accerr_sticky", SelErr, 32'h1);
    expect_val("unmapped_ram10", SelRd, 32'hDEAD_BEEF);
    step();

    // Exit latch
    drive(1'b1, AExit, 32'h2A);
    expect_val("done_before", SelDone, 32'h0);
    step();
    drive(1'b1, AExit, 32'h7);
    expect_val("done_set", SelDone, 32'h1);
    expect_val("exit_code", SelExit, 32'h2A);
    step();
    drive(1'b0, AExit, 32'h0);
    expect_val("exit_rd0", SelRd, 32'h0);
    expect_val("exit_code_kept", SelExit, 32'h2A);
    step();

    // Asynchronous reset mid-operation with a coincident write.
    drive(1'b1, ALed, 32'h11);
    reset = 1'b0;
    expect_val("async_led", SelLed, 32'h0);
    expect_val("async_done", SelDone, 32'h0);
    expect_val("async_exit", SelExit, 32'h0);
    expect_val("async_accerr", SelErr, 32'h0);
    expect_val("async_irq", SelIrq, 32'h0);
    expect_val("async_led_rd", SelRd, 32'h0);
    step();
    drive(1'b1, 32'h10, 32'h0BAD_0BAD);
    step();
    reset = 1'b1;
    drive(1'b0, ATcnt, 32'h0);
    expect_val("post_rst_led", SelLed, 32'h0);
`ifdef DMEM_TIMER_EN
    expect_val("post_rst_tcnt", SelRd, 32'h0);
`endif
    step();
    drive(1'b0, 32'h10, 32'h0);
    expect_val("rst_write_dropped", SelRd, 32'hDEAD_BEEF);
    step();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
